// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between producers, the round-robin arbiter and the bit-serial FIFO.
// The master modport is the arbiter's view; the slave modport is the producers' and FIFO's view.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 1
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_din;
  logic                      fifo_rd_done;

  modport master (
    input  req_valid, req_data, fifo_rd_done,
    output req_ready, fifo_wr_en, fifo_din
  );

  modport slave (
    output req_valid, req_data, fifo_rd_done,
    input  req_ready, fifo_wr_en, fifo_din
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among NUM_REQ producers.
// Free space is tracked with a local credit counter, so the FIFO full flag is not needed.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 1,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned GW = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_wr_arbiter_if.master     bus,
  output logic [CW-1:0]         credits,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic                  overflow_err
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_credits, w_credits_nxt;
  logic [GW-1:0]     r_grant, w_grant_nxt;
  logic [GW-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [GW-1:0]     w_winner, w_idx;
  logic              w_found;
  logic [BW-1:0]     r_burst_cnt, w_burst_cnt_nxt;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_din;
  logic              r_ovf;
  logic              w_can_write, w_xfer, w_rd_eff;

  // Ready depends only on registered state, never on req_valid.
  assign w_can_write = (r_state == S_BURST) && (r_credits != '0);
  assign w_xfer      = w_can_write && bus.req_valid[r_grant];
  assign w_rd_eff    = bus.fifo_rd_done && (r_credits != CW'(DEPTH));

  always_comb begin
    w_credits_nxt = r_credits;
    case ({w_xfer, w_rd_eff})
      2'b10:   w_credits_nxt = r_credits - CW'(1);
      2'b01:   w_credits_nxt = r_credits + CW'(1);
      default: w_credits_nxt = r_credits;
    endcase
  end

  // First valid producer searching upward from the one after the last winner.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = GW'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_cnt_nxt = r_burst_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found && (r_credits != '0)) begin
          w_state_nxt     = S_BURST;
          w_grant_nxt     = w_winner;
          w_rr_ptr_nxt    = w_winner;
          w_burst_cnt_nxt = '0;
        end
      end
      S_BURST: begin
        if (w_xfer) w_burst_cnt_nxt = r_burst_cnt + BW'(1);
        if ((w_xfer && (r_burst_cnt == BW'(MAX_BURST - 1))) ||
            !bus.req_valid[r_grant] || (w_credits_nxt == '0))
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_credits   <= CW'(DEPTH);
      r_grant     <= '0;
      r_rr_ptr    <= GW'(NUM_REQ - 1);
      r_burst_cnt <= '0;
      r_wr_en     <= 1'b0;
      r_din       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_credits   <= w_credits_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_wr_en     <= w_xfer;
      if (w_xfer) r_din <= bus.req_data[32'(r_grant) * DATA_W +: DATA_W];
      if (bus.fifo_rd_done && (r_credits == CW'(DEPTH))) r_ovf <= 1'b1;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (w_can_write) bus.req_ready[r_grant] = 1'b1;
  end

  assign bus.fifo_wr_en = r_wr_en;
  assign bus.fifo_din   = r_din;
  assign credits        = r_credits;
  assign grant_id       = r_grant;
  assign busy           = (r_state == S_BURST);
  assign overflow_err   = r_ovf;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a rule-level reference model.
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int DW    = 1;
  localparam int DEPTH = 8;
  localparam int MB    = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int GW    = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] credits;
  logic [GW-1:0] grant_id;
  logic          busy;
  logic          overflow_err;

  int n_cmp = 0;
  int n_err = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .DEPTH(DEPTH), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .credits(credits), .grant_id(grant_id), .busy(busy), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: free slots, who holds the port, how many words that holder may
  // still send, and which producer is favoured at the next arbitration.
  int            m_free;
  bit            m_owned;
  int            m_owner;
  int            m_left;
  int            m_pref;
  bit            m_wr;
  logic [DW-1:0] m_din;
  bit            m_ovf;
  bit            m_xfer;
  int            m_xid;

  function automatic void model_reset();
    m_free = DEPTH; m_owned = 0; m_owner = 0; m_left = 0; m_pref = 0;
    m_wr = 0; m_din = '0; m_ovf = 0; m_xfer = 0; m_xid = 0;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r = '0;
    if (m_owned && m_free > 0) r[m_owner] = 1'b1;
    return r;
  endfunction

  // Applies one clock edge worth of rules to the model using the inputs now driven.
  function automatic void model_step();
    logic [N-1:0] v = bus.req_valid;
    bit rd = bus.fifo_rd_done;
    int free_after;
    m_xfer = m_owned && (m_free > 0) && v[m_owner];
    m_xid  = m_owner;
    free_after = m_free - (m_xfer ? 1 : 0) + ((rd && m_free < DEPTH) ? 1 : 0);
    if (rd && m_free == DEPTH) m_ovf = 1;
    m_wr = m_xfer;
    if (m_xfer) m_din = bus.req_data[m_owner*DW +: DW];
    if (!m_owned) begin
      if (v != '0 && m_free > 0) begin
        for (int k = 0; k < N; k++) begin
          if (!m_owned && v[(m_pref + k) % N]) begin
            m_owned = 1;
            m_owner = (m_pref + k) % N;
          end
        end
        m_pref = (m_owner + 1) % N;
        m_left = MB;
      end
    end else begin
      if (m_xfer) m_left = m_left - 1;
      if (m_left == 0 || !v[m_owner] || free_after == 0) m_owned = 0;
    end
    m_free = free_after;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    bus.req_valid = '0; bus.req_data = '0; bus.fifo_rd_done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (credits !== CW'(DEPTH)) begin n_err++; $display("FAIL reset_credits: got %0d expected %0d", credits, DEPTH); end
    n_cmp++; if (bus.req_ready !== '0) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
    n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b expected 0", bus.fifo_wr_en); end
    n_cmp++; if (bus.fifo_din !== '0) begin n_err++; $display("FAIL reset_din: got %b expected 0", bus.fifo_din); end
    n_cmp++; if (grant_id !== '0) begin n_err++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", overflow_err); end
  endtask

  task automatic test_single();
    apply_reset();
    bus.req_valid = 4'b0001; bus.req_data = 4'b0001;
    tick();
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b expected 0001", bus.req_ready); end
    n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL single_early_wr: got %b expected 0", bus.fifo_wr_en); end
    tick();
    n_cmp++; if (bus.fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL single_wr_en: got %b expected 1", bus.fifo_wr_en); end
    n_cmp++; if (bus.fifo_din !== 1'b1) begin n_err++; $display("FAIL single_din: got %b expected 1", bus.fifo_din); end
    n_cmp++; if (credits !== CW'(DEPTH - 1)) begin n_err++; $display("FAIL single_credits: got %0d expected %0d", credits, DEPTH - 1); end
    bus.req_valid = '0; bus.req_data = '0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_drop: got %b expected 0", busy); end
    n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL single_wr_drop: got %b expected 0", bus.fifo_wr_en); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp;
    logic [N-1:0] one = 1;
    apply_reset();
    bus.req_valid = '1; bus.req_data = N'($urandom); bus.fifo_rd_done = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick();
      exp = ((c % 5) < 4) ? (one << ((c / 5) % N)) : '0;
      n_cmp++; if (bus.req_ready !== exp) begin n_err++; $display("FAIL fair_ready[c=%0d]: got %b expected %b", c, bus.req_ready, exp); end
      if ((c % 5) == 0) begin
        n_cmp++; if (grant_id !== GW'((c / 5) % N)) begin n_err++; $display("FAIL fair_grant[c=%0d]: got %0d expected %0d", c, grant_id, (c / 5) % N); end
      end
    end
    bus.req_valid = '0; bus.fifo_rd_done = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    int wr = 0;
    apply_reset();
    bus.req_valid = 4'b0100; bus.req_data = N'($urandom);
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.fifo_wr_en) wr++;
    end
    n_cmp++; if (wr != DEPTH) begin n_err++; $display("FAIL fill_writes: got %0d expected %0d", wr, DEPTH); end
    n_cmp++; if (credits !== '0) begin n_err++; $display("FAIL fill_credits: got %0d expected 0", credits); end
    n_cmp++; if (bus.req_ready !== '0) begin n_err++; $display("FAIL fill_ready: got %b expected 0000", bus.req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fill_busy: got %b expected 0", busy); end
    bus.fifo_rd_done = 1'b1;
    tick();
    bus.fifo_rd_done = 1'b0;
    n_cmp++; if (credits !== CW'(1)) begin n_err++; $display("FAIL fill_one_credit: got %0d expected 1", credits); end
    wr = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.fifo_wr_en) wr++;
    end
    n_cmp++; if (wr != 1) begin n_err++; $display("FAIL fill_extra_write: got %0d expected 1", wr); end
    n_cmp++; if (credits !== '0) begin n_err++; $display("FAIL fill_refill_credits: got %0d expected 0", credits); end
  endtask

  task automatic test_simultaneous();
    int budget = 0;
    apply_reset();
    bus.req_valid = 4'b0010; bus.req_data = 4'b0010;
    while (credits !== CW'(5) && budget < 20) begin
      tick();
      budget++;
    end
    n_cmp++; if (credits !== CW'(5)) begin n_err++; $display("FAIL simul_reach5: got %0d expected 5 within 20 cycles", credits); end
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL simul_ready: got %b expected 0010", bus.req_ready); end
    bus.fifo_rd_done = 1'b1;
    tick();
    bus.fifo_rd_done = 1'b0;
    n_cmp++; if (credits !== CW'(5)) begin n_err++; $display("FAIL simul_credits: got %0d expected 5", credits); end
    n_cmp++; if (bus.fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL simul_wr_en: got %b expected 1", bus.fifo_wr_en); end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_overflow();
    apply_reset();
    bus.fifo_rd_done = 1'b1;
    tick();
    bus.fifo_rd_done = 1'b0;
    n_cmp++; if (credits !== CW'(DEPTH)) begin n_err++; $display("FAIL ovf_credits: got %0d expected %0d", credits, DEPTH); end
    n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", overflow_err); end
    bus.req_valid = 4'b0001; bus.req_data = 4'b0000;
    repeat (6) tick();
    bus.req_valid = '0;
    n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", overflow_err); end
    apply_reset();
    n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b expected 0", overflow_err); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    bus.req_valid = 4'b0100; bus.req_data = 4'b0100;
    tick();
    tick();
    n_cmp++; if (bus.fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL midrst_first_wr: got %b expected 1", bus.fifo_wr_en); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== '0) begin n_err++; $display("FAIL midrst_ready: got %b expected 0000", bus.req_ready); end
    n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL midrst_wr_en: got %b expected 0", bus.fifo_wr_en); end
    n_cmp++; if (bus.fifo_din !== '0) begin n_err++; $display("FAIL midrst_din: got %b expected 0", bus.fifo_din); end
    n_cmp++; if (credits !== CW'(DEPTH)) begin n_err++; $display("FAIL midrst_credits: got %0d expected %0d", credits, DEPTH); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_cmp++; if (grant_id !== '0) begin n_err++; $display("FAIL midrst_grant: got %0d expected 0", grant_id); end
    @(negedge clk);
    bus.req_valid = 4'b1010; bus.req_data = 4'b1010;
    rst = 1'b0;
    model_reset();
    tick();
    n_cmp++; if (grant_id !== GW'(1)) begin n_err++; $display("FAIL midrst_regrant: got %0d expected 1", grant_id); end
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL midrst_reready: got %b expected 0010", bus.req_ready); end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    bit            pv [N];
    logic [DW-1:0] pd [N];
    logic [N-1:0]  er;
    apply_reset();
    for (int i = 0; i < N; i++) begin pv[i] = 0; pd[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin pv[i] = 1; pd[i] = DW'($urandom); end
        bus.req_valid[i]         = pv[i];
        bus.req_data[i*DW +: DW] = pd[i];
      end
      bus.fifo_rd_done = ($urandom_range(0, 3) == 0);
      tick();
      if (m_xfer) pv[m_xid] = 0;
      er = m_ready();
      n_cmp++; if (bus.req_ready !== er) begin n_err++; $display("FAIL rnd_ready[c=%0d]: got %b expected %b", c, bus.req_ready, er); end
      n_cmp++; if (bus.fifo_wr_en !== m_wr) begin n_err++; $display("FAIL rnd_wr_en[c=%0d]: got %b expected %b", c, bus.fifo_wr_en, m_wr); end
      n_cmp++; if (bus.fifo_din !== m_din) begin n_err++; $display("FAIL rnd_din[c=%0d]: got %b expected %b", c, bus.fifo_din, m_din); end
      n_cmp++; if (credits !== CW'(m_free)) begin n_err++; $display("FAIL rnd_credits[c=%0d]: got %0d expected %0d", c, credits, m_free); end
      n_cmp++; if (busy !== m_owned) begin n_err++; $display("FAIL rnd_busy[c=%0d]: got %b expected %b", c, busy, m_owned); end
      n_cmp++; if (grant_id !== GW'(m_owner)) begin n_err++; $display("FAIL rnd_grant[c=%0d]: got %0d expected %0d", c, grant_id, m_owner); end
      n_cmp++; if (overflow_err !== m_ovf) begin n_err++; $display("FAIL rnd_ovf[c=%0d]: got %b expected %b", c, overflow_err, m_ovf); end
    end
    bus.req_valid = '0; bus.fifo_rd_done = 1'b0;
  endtask

  initial begin
    bus.req_valid = '0; bus.req_data = '0; bus.fifo_rd_done = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_fill();
    test_simultaneous();
    test_overflow();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "time limit");
  end
endmodule
